// File: rtl/shift_arb_pkg.sv
// Shared constants, FSM state type and the ShiftL64 helper for the shift round-robin arbiter.
package shift_arb_pkg;

    localparam int unsigned DATA_W  = 64;
    localparam int unsigned SHAMT_W = 8;
    localparam int unsigned CNT_W   = 16;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    // ShiftL64: amounts of 64 or more push every operand bit out, giving zero.
    function automatic logic [DATA_W-1:0] shift_l64(input logic [DATA_W-1:0] data,
                                                    input logic [SHAMT_W-1:0] n);
        logic [DATA_W-1:0] res;
        if (n[SHAMT_W-1:6] != '0) begin
            res = '0;
        end else begin
            res = data << n[5:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Round-robin grant: scans valid starting at ptr, returns one-hot grant and its index.
module rr_grant
    import shift_arb_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            any_valid
);

    always_comb begin
        int j;
        grant     = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        for (int k = 0; k < int'(NREQ); k++) begin
            j = (int'(ptr) + k) % int'(NREQ);
            if (!any_valid && valid[j]) begin
                any_valid = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/shift_rr_arbiter.sv
// Round-robin arbiter sharing one 64-bit left shifter; one registered result stage.
// Optional per-requester accept counters when SHIFT_ARB_STATS_EN is defined.
module shift_rr_arbiter
    import shift_arb_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*SHAMT_W-1:0] req_n,
    input  logic [NREQ*DATA_W-1:0]  req_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_W-1:0]       rsp_data,
    output logic [IDW-1:0]          rsp_id
`ifdef SHIFT_ARB_STATS_EN
    ,
    output logic [NREQ*CNT_W-1:0]   grant_cnt
`endif
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [IDW-1:0]    rsp_id_q, rsp_id_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;

    logic [NREQ-1:0]    grant;
    logic [IDW-1:0]     grant_idx;
    logic               any_valid;
    logic               can_accept;
    logic               accept;
    logic [SHAMT_W-1:0] sel_n;
    logic [DATA_W-1:0]  sel_data;

    rr_grant #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_grant (
        .valid     (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_valid (any_valid)
    );

    assign can_accept = (state_q == EMPTY) || rsp_ready;
    // Ready is forced low during reset even though the grant logic is combinational.
    assign req_ready  = (rst || !can_accept) ? '0 : grant;
    assign accept     = any_valid && can_accept && !rst;

    always_comb begin
        sel_n    = '0;
        sel_data = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (grant[i]) begin
                sel_n    = req_n[i*SHAMT_W +: SHAMT_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        rr_ptr_d   = rr_ptr_q;
        if (accept) begin
            rsp_data_d = shift_l64(sel_data, sel_n);
            rsp_id_d   = grant_idx;
            rr_ptr_d   = (int'(grant_idx) == int'(NREQ) - 1) ? '0 : grant_idx + 1'b1;
        end
        unique case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL:  if (rsp_ready && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

`ifdef SHIFT_ARB_STATS_EN
    logic [NREQ*CNT_W-1:0] cnt_q, cnt_d;

    // Counters saturate so a long-running requester never appears to have restarted.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (accept && grant[i] && (cnt_q[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
                cnt_d[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_shift_rr_arbiter.sv
// Directed self-checking bench for shift_rr_arbiter with NREQ=2.
module tb_shift_rr_arbiter;

    logic         clk;
    logic         rst;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [15:0]  req_n;
    logic [127:0] req_data;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [63:0]  rsp_data;
    logic [0:0]   rsp_id;
`ifdef SHIFT_ARB_STATS_EN
    logic [31:0]  grant_cnt;
`endif

    int total = 0;
    int bad   = 0;

    shift_rr_arbiter #(
        .NREQ (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_n     (req_n),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
`ifdef SHIFT_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rsp(input string tag, input logic v, input logic [63:0] d,
                             input logic id);
        check({tag, "_valid"}, 64'(rsp_valid), 64'(v));
        check({tag, "_data"}, rsp_data, d);
        check({tag, "_id"}, 64'(rsp_id), 64'(id));
    endtask

    initial begin
        logic exp_id [4];
        exp_id = '{1'b1, 1'b0, 1'b1, 1'b0};

        rst       = 1'b1;
        req_valid = 2'b01;
        req_n     = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        #3;
        check_rsp("reset", 1'b0, 64'h0, 1'b0);
        check("reset_ready", 64'(req_ready), 64'h0);
        req_valid = 2'b00;
        step();
        rst = 1'b0;
        step();

        // Single requester 0: 1 << 4
        req_valid = 2'b01;
        req_n     = {8'd0, 8'd4};
        req_data  = {64'h0, 64'h1};
        rsp_ready = 1'b1;
        #1;
        check("single_ready", 64'(req_ready), 64'h1);
        step();
        check_rsp("single", 1'b1, 64'h10, 1'b0);
        req_valid = 2'b00;
        step();
        check("drain_valid", 64'(rsp_valid), 64'h0);

        // Both valid; pointer now at 1 so grants go 1,0,1,0
        req_valid = 2'b11;
        req_n     = {8'd2, 8'd1};
        req_data  = {64'h3, 64'h1};
        #1;
        check("both_ready", 64'(req_ready), 64'h2);
        for (int i = 0; i < 4; i++) begin
            step();
            check_rsp("alt", 1'b1, exp_id[i] ? 64'hC : 64'h2, exp_id[i]);
        end

        // Backpressure: holds id0/0x2 while rsp_ready is low
        rsp_ready = 1'b0;
        #1;
        check("bp_ready", 64'(req_ready), 64'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_rsp("bp_hold", 1'b1, 64'h2, 1'b0);
            check("bp_ready_hold", 64'(req_ready), 64'h0);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(req_ready), 64'h2);
        step();
        check_rsp("bp_release", 1'b1, 64'hC, 1'b1);
        req_valid = 2'b00;
        step();
        check("bp_drain", 64'(rsp_valid), 64'h0);

        // Shift boundaries on requester 0 (pointer is 0 again)
        req_valid = 2'b01;
        req_n     = {8'd0, 8'd63};
        req_data  = {64'h0, 64'h1};
        step();
        check_rsp("n63", 1'b1, 64'h8000_0000_0000_0000, 1'b0);
        req_n    = {8'd0, 8'd64};
        req_data = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
        step();
        check_rsp("n64", 1'b1, 64'h0, 1'b0);
        req_n = {8'd0, 8'hFF};
        step();
        check_rsp("nFF", 1'b1, 64'h0, 1'b0);
        req_n    = {8'd0, 8'd0};
        req_data = {64'h0, 64'hDEAD_BEEF_0000_1234};
        step();
        check_rsp("n0", 1'b1, 64'hDEAD_BEEF_0000_1234, 1'b0);
        req_valid = 2'b10;
        req_n     = {8'd8, 8'd0};
        req_data  = {64'h0000_0000_0000_1234, 64'h0};
        step();
        check_rsp("req1_n8", 1'b1, 64'h0000_0000_0012_3400, 1'b1);

        // Reset while FULL clears the result immediately
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        step();
        check("pre_reset_full", 64'(rsp_valid), 64'h1);
        rst = 1'b1;
        #1;
        check_rsp("mid_reset", 1'b0, 64'h0, 1'b0);
        step();
        rst       = 1'b0;
        rsp_ready = 1'b1;
        step();

`ifdef SHIFT_ARB_STATS_EN
        check("cnt_reset", 64'(grant_cnt), 64'h0);
        req_valid = 2'b10;
        req_n     = {8'd1, 8'd0};
        req_data  = {64'h1, 64'h0};
        for (int i = 0; i < 10; i++) step();
        check("cnt_req1_10", 64'(grant_cnt[31:16]), 64'd10);
        check("cnt_req0_0", 64'(grant_cnt[15:0]), 64'd0);
        for (int i = 0; i < 65530; i++) step();
        check("cnt_req1_sat", 64'(grant_cnt[31:16]), 64'hFFFF);
        req_valid = 2'b00;
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
